deadtime_gen: RTL and testbench
===============================

# deadtime_gen

- Drive stage that sits directly downstream of the DPWM counter/comparator.
- Converts the single registered `duty` waveform into complementary high-side and low-side gate commands for the synchronous buck power stage.
- Inserts independently programmable rising- and falling-edge dead times.
- Swallows pulses too narrow to survive the dead time, so the two gates are never high in the same cycle.

## Interface
- `DT_W`, default 4: width of the dead-time programming inputs and the internal dead-time counter.
- `clk` input 1: system clock, the same clock that drives the DPWM.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: power-stage enable. When 0, both gates are held off.
- `duty` input 1: registered PWM output from the DPWM.
- `dt_rise` input DT_W: dead time before `hs_gate` turns on, in cycles minus one.
- `dt_fall` input DT_W: dead time before `ls_gate` turns on, in cycles minus one.
- `zc_det` input 1: inductor-current zero-crossing flag. Used only when `DIODE_EMULATION_EN` is defined.
- `hs_gate` output 1: high-side switch command.
- `ls_gate` output 1: low-side switch command.
- `pulse_drop` output 1: one-cycle strobe when a high-side pulse is swallowed.

## Operation
- Moore FSM with registered outputs. Gates change on the same edge as the state register.
- Outputs by state:
  - `ls_gate`=1 only in LS_ON.
  - `hs_gate`=1 only in HS_ON.
  - All other states drive both gates to 0.
- States: IDLE, LS_ON, DT_R, HS_ON, DT_F, DE_OFF (DE_OFF exists only with the macro).
- `en`=0 has top priority: any state goes to IDLE on the next edge. The counter clears.
- IDLE, with `en`=1: go to DT_R if `duty`=1, otherwise to LS_ON.
- LS_ON: if `duty`=1, go to DT_R and load the counter with `dt_rise`.
- DT_R:
  - If `duty`=0, go to LS_ON and pulse `pulse_drop` for one cycle.
  - Else, if counter=0, go to HS_ON.
  - Otherwise decrement the counter.
- HS_ON: if `duty`=0, go to DT_F and load the counter with `dt_fall`.
- DT_F:
  - If counter≠0, decrement. `duty` is ignored until the counter reaches 0.
  - If counter=0 and `duty`=1, go to DT_R and reload with `dt_rise`. No runt `ls_gate` pulse is produced.
  - If counter=0 and `duty`=0, go to LS_ON.
- `dt_rise` and `dt_fall` are sampled only on load. A change mid-interval takes effect at the next dead time.
- Counter arithmetic is unsigned DT_W-bit. It never decrements below 0, so there is no wrap.
- `hs_gate` and `ls_gate` are never both 1 in any cycle, including across `en` toggles and reset.

## Timing
- Reset values: state=IDLE, counter=0, `hs_gate`=0, `ls_gate`=0, `pulse_drop`=0.
- Latency: 1 cycle from `duty` changing to the first gate edge.
- Both-off interval:
  - Exactly `dt_rise`+1 cycles before `hs_gate` rises.
  - Exactly `dt_fall`+1 cycles before `ls_gate` rises.
  - A value of 0 gives a 1-cycle gap.
- High-side width equals the `duty` high width minus (`dt_rise`+1) cycles.
- If the `duty` high width is ≤ `dt_rise`+1 cycles, `hs_gate` stays 0 and `pulse_drop` fires once, on the edge that returns to LS_ON.
- `pulse_drop` is high for exactly one cycle per dropped pulse.
- When `duty` rises in the same cycle that `en` falls, the FSM goes to IDLE.
- Reset asserted mid-pulse: both gates go to 0 immediately, asynchronously.

## Configuration
- Macro: `DEADTIME_GEN_DIODE_EMULATION_EN`.
- Defined:
  - In LS_ON, `zc_det`=1 with `duty`=0 sends the FSM to DE_OFF, with both gates off. This blocks reverse inductor current at light load.
  - DE_OFF goes to DT_R (load `dt_rise`) when `duty`=1.
  - If `duty`=1 and `zc_det`=1 in the same cycle in LS_ON, `duty` wins and the FSM goes to DT_R.
- Undefined:
  - `zc_det` is ignored and DE_OFF is not synthesized.
  - Behaviour is otherwise identical to the defined case.

## Test plan
- Reset with `en`=1 and `duty` toggling → both gates 0 while `rst`=1. After release, the FSM is in LS_ON or DT_R within 1 cycle.
- `dt_rise`=3, `dt_fall`=2, `duty` high 20 cycles in a 64-cycle period → `ls_gate` falls 1 cycle after `duty` rises. `hs_gate` is high for 16 cycles. Both are off for 4 cycles before HS and 3 cycles before LS.
- `dt_rise`=3, `duty` high 3 cycles → `hs_gate` never rises. `pulse_drop` fires exactly once. `ls_gate` returns high with no overlap.
- `dt_rise`=0, `dt_fall`=0 → exactly 1 both-off cycle at each transition. A 2-cycle `duty` pulse yields 1 cycle of `hs_gate`.
- `en` dropped while in HS_ON → both gates 0 on the next edge. Re-enable with `duty`=0 → LS_ON one cycle later.
- Macro defined, `zc_det` pulsed in LS_ON with `duty`=0 → `ls_gate` 0 next cycle. On the next `duty` rise, `hs_gate` rises after `dt_rise`+1 cycles. Macro undefined, same stimulus → `ls_gate` is unaffected.

Source files
------------

// File: rtl/deadtime_gen.sv
// Complementary high/low-side gate driver with programmable rising/falling dead time.
// Optional diode emulation (zero-crossing low-side cut-off) under `DEADTIME_GEN_DIODE_EMULATION_EN`.
module deadtime_gen #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            duty,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            zc_det,
    output logic            hs_gate,
    output logic            ls_gate,
    output logic            pulse_drop
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LS_ON  = 3'd1,
        DT_R   = 3'd2,
        HS_ON  = 3'd3,
        DT_F   = 3'd4
`ifdef DEADTIME_GEN_DIODE_EMULATION_EN
        ,DE_OFF = 3'd5
`endif
    } state_t;

    state_t          state_q;
    logic [DT_W-1:0] cnt_q;
    logic            hs_q;
    logic            ls_q;
    logic            drop_q;

`ifndef DEADTIME_GEN_DIODE_EMULATION_EN
    logic unused_zc;
    assign unused_zc = zc_det;
`endif

    // Gate registers are cleared every cycle and only set for the state being entered,
    // so both gates can never be high together, whatever the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
            drop_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (duty) begin
                            state_q <= DT_R;
                            cnt_q   <= dt_rise;
                        end else begin
                            state_q <= LS_ON;
                            ls_q    <= 1'b1;
                        end
                    end
                    LS_ON: begin
                        if (duty) begin
                            state_q <= DT_R;
                            cnt_q   <= dt_rise;
                        end
`ifdef DEADTIME_GEN_DIODE_EMULATION_EN
                        else if (zc_det) begin
                            state_q <= DE_OFF;
                        end
`endif
                        else begin
                            ls_q <= 1'b1;
                        end
                    end
                    DT_R: begin
                        if (!duty) begin
                            state_q <= LS_ON;
                            ls_q    <= 1'b1;
                            drop_q  <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q <= HS_ON;
                            hs_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    HS_ON: begin
                        if (!duty) begin
                            state_q <= DT_F;
                            cnt_q   <= dt_fall;
                        end else begin
                            hs_q <= 1'b1;
                        end
                    end
                    DT_F: begin
                        // duty is deliberately ignored until the falling dead time expires
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (duty) begin
                            state_q <= DT_R;
                            cnt_q   <= dt_rise;
                        end else begin
                            state_q <= LS_ON;
                            ls_q    <= 1'b1;
                        end
                    end
`ifdef DEADTIME_GEN_DIODE_EMULATION_EN
                    DE_OFF: begin
                        if (duty) begin
                            state_q <= DT_R;
                            cnt_q   <= dt_rise;
                        end
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign hs_gate    = hs_q;
    assign ls_gate    = ls_q;
    assign pulse_drop = drop_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: vector table, directed dead-time corner sequences, random vs. elapsed-time model.
module tb_deadtime_gen;
    localparam int DT_W = 4;
`ifdef DEADTIME_GEN_DIODE_EMULATION_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            duty;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            zc_det;
    logic            hs_gate;
    logic            ls_gate;
    logic            pulse_drop;

    always #5 clk = ~clk;

    deadtime_gen #(.DT_W(DT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .duty(duty), .dt_rise(dt_rise), .dt_fall(dt_fall),
        .zc_det(zc_det), .hs_gate(hs_gate), .ls_gate(ls_gate), .pulse_drop(pulse_drop)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: gates off-phase measured as elapsed cycles against a target of dt+1.
    localparam int M_OFF = 0, M_LS = 1, M_GAPR = 2, M_HS = 3, M_GAPF = 4, M_DE = 5;
    int m_mode, m_el, m_need;
    bit m_drop;

    task automatic model_reset();
        m_mode = M_OFF; m_el = 0; m_need = 0; m_drop = 1'b0;
    endtask

    task automatic start_gap_r();
        m_mode = M_GAPR; m_need = int'(dt_rise) + 1; m_el = 1;
    endtask

    task automatic model_step();
        m_drop = 1'b0;
        if (!en) begin
            m_mode = M_OFF; m_el = 0;
        end else begin
            case (m_mode)
                M_OFF:  if (duty) start_gap_r(); else m_mode = M_LS;
                M_LS:   if (duty) start_gap_r(); else if (DE && zc_det) m_mode = M_DE;
                M_GAPR: if (!duty) begin m_mode = M_LS; m_drop = 1'b1; end
                        else if (m_el == m_need) m_mode = M_HS;
                        else m_el++;
                M_HS:   if (!duty) begin m_mode = M_GAPF; m_need = int'(dt_fall) + 1; m_el = 1; end
                M_GAPF: if (m_el < m_need) m_el++;
                        else if (duty) start_gap_r();
                        else m_mode = M_LS;
                M_DE:   if (duty) start_gap_r();
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        check("model", {5'd0, hs_gate, ls_gate, pulse_drop},
              {5'd0, m_mode == M_HS, m_mode == M_LS, m_drop});
        check("overlap", {7'd0, hs_gate & ls_gate}, 8'd0);
    endtask

    bit hq[$], lq[$], dq[$];

    task automatic pwm_rec(input int hi, input int period);
        hq.delete(); lq.delete(); dq.delete();
        for (int i = 0; i < period; i++) begin
            duty = (i < hi);
            tick();
            hq.push_back(hs_gate); lq.push_back(ls_gate); dq.push_back(pulse_drop);
        end
        duty = 1'b0;
    endtask

    function automatic int count_q(input bit q[$]);
        int n = 0;
        foreach (q[i]) n += q[i];
        return n;
    endfunction

    function automatic int first_hs();
        foreach (hq[i]) if (hq[i]) return i;
        return -1;
    endfunction

    function automatic int last_hs();
        int r = -1;
        foreach (hq[i]) if (hq[i]) r = i;
        return r;
    endfunction

    function automatic int off_before(input int idx);
        int n = 0;
        for (int i = idx - 1; i >= 0 && !hq[i] && !lq[i]; i--) n++;
        return n;
    endfunction

    function automatic int off_after(input int idx);
        int n = 0;
        for (int i = idx + 1; i < hq.size() && !hq[i] && !lq[i]; i++) n++;
        return n;
    endfunction

    typedef struct {
        bit       en;
        bit       duty;
        bit [3:0] dtr;
        bit [3:0] dtf;
        bit [2:0] exp;  // {hs, ls, drop}
    } vec_t;

    vec_t tbl[20];
    int   rl;

    initial begin
        // dt_rise=1, dt_fall=0 walk through every transition
        tbl[0]  = '{1'b0, 1'b0, 4'd1, 4'd0, 3'b000};
        tbl[1]  = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b010};
        tbl[2]  = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[3]  = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[4]  = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b100};
        tbl[5]  = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b100};
        tbl[6]  = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b000};
        tbl[7]  = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b010};
        tbl[8]  = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[9]  = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b011};
        tbl[10] = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b010};
        tbl[11] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[12] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[13] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b100};
        tbl[14] = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b000};
        tbl[15] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[16] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[17] = '{1'b1, 1'b1, 4'd1, 4'd0, 3'b100};
        tbl[18] = '{1'b0, 1'b1, 4'd1, 4'd0, 3'b000};
        tbl[19] = '{1'b1, 1'b0, 4'd1, 4'd0, 3'b010};

        rst = 1'b1; en = 1'b1; duty = 1'b0; zc_det = 1'b0; dt_rise = 4'd3; dt_fall = 4'd2;
        model_reset();

        // reset held with en=1 and duty toggling
        for (int i = 0; i < 4; i++) begin
            duty = ~duty;
            @(posedge clk); #1;
            check("rst_gates", {6'd0, hs_gate, ls_gate}, 8'd0);
            check("rst_drop", {7'd0, pulse_drop}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b0; duty = 1'b0;
        tick();
        check("rst_release_ls", {7'd0, ls_gate}, 8'd1);

        // vector table
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en; duty = tbl[i].duty; dt_rise = tbl[i].dtr; dt_fall = tbl[i].dtf;
            tick();
            check($sformatf("vec%0d", i), {5'd0, hs_gate, ls_gate, pulse_drop}, {5'd0, tbl[i].exp});
        end

        // dt_rise=3, dt_fall=2, 20-of-64 duty
        en = 1'b1; duty = 1'b0; dt_rise = 4'd3; dt_fall = 4'd2;
        repeat (5) tick();
        pwm_rec(20, 64);
        check("p1_ls_fall", {7'd0, lq[0]}, 8'd0);
        check("p1_hs_width", 8'(count_q(hq)), 8'd16);
        check("p1_off_pre_hs", 8'(off_before(first_hs())), 8'd4);
        check("p1_off_pre_ls", 8'(off_after(last_hs())), 8'd3);
        check("p1_ls_back", {7'd0, lq[last_hs() + 4]}, 8'd1);

        // narrow pulse swallowed
        repeat (3) tick();
        pwm_rec(3, 16);
        check("p2_no_hs", 8'(count_q(hq)), 8'd0);
        check("p2_drop_once", 8'(count_q(dq)), 8'd1);
        check("p2_ls_end", {7'd0, lq[15]}, 8'd1);

        // zero dead times, 2-cycle pulse
        dt_rise = 4'd0; dt_fall = 4'd0;
        repeat (3) tick();
        pwm_rec(2, 8);
        check("p3_hs_width", 8'(count_q(hq)), 8'd1);
        check("p3_off_pre_hs", 8'(off_before(first_hs())), 8'd1);
        check("p3_off_pre_ls", 8'(off_after(last_hs())), 8'd1);

        // en dropped in HS_ON, then re-enabled with duty low
        duty = 1'b1;
        repeat (3) tick();
        check("en_hs_on", {7'd0, hs_gate}, 8'd1);
        en = 1'b0;
        tick();
        check("en_off_gates", {6'd0, hs_gate, ls_gate}, 8'd0);
        en = 1'b1; duty = 1'b0;
        tick();
        check("en_back_ls", {7'd0, ls_gate}, 8'd1);

        // asynchronous reset mid-pulse
        duty = 1'b1;
        repeat (3) tick();
        check("arst_hs_on", {7'd0, hs_gate}, 8'd1);
        #2 rst = 1'b1;
        #1 check("arst_gates", {6'd0, hs_gate, ls_gate}, 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; duty = 1'b0;
        repeat (2) tick();

        // zero-crossing in LS_ON, then next duty rise
        dt_rise = 4'd2; dt_fall = 4'd1;
        repeat (3) tick();
        zc_det = 1'b1;
        tick();
        zc_det = 1'b0;
        check("de_ls_cut", {7'd0, ls_gate}, DE ? 8'd0 : 8'd1);
        tick();
        check("de_ls_hold", {7'd0, ls_gate}, DE ? 8'd0 : 8'd1);
        pwm_rec(10, 20);
        check("de_hs_delay", 8'(first_hs()), 8'd3);

        // randomized run against the model
        rl = 1;
        for (int i = 0; i < 3000; i++) begin
            rl--;
            if (rl <= 0) begin
                duty = ~duty;
                rl = int'($urandom_range(1, 12));
            end
            if ($urandom_range(0, 49) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 19) == 0) dt_rise = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) dt_fall = 4'($urandom_range(0, 5));
            zc_det = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
